vsync_provider: RTL and testbench

Vertical timing stage of the VGA chain, directly downstream of the horizontal sync generator. It consumes that stage's HSYNC and detects one line tick per scan line. From the ticks it counts lines, drives the active-low VSYNC, and produces the visible-row coordinate Y, a line-visible flag, a frame-start pulse and a frame counter for the pixel generator. Default timing is 640x480@60 Hz, 525 lines per frame.

---
 rtl/vsync_provider.sv | 83 ++++++++
 tb/tb_vsync_provider.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vsync_provider.sv
// rtl/vsync_provider.sv - vertical timing stage: line ticks from HSYNC, VSYNC, row coordinate, frame pulses
module vsync_provider #(
  parameter int VerticalFrontPorch = 10,
  parameter int VSYNCPulse         = 2,
  parameter int VerticalBackPorch  = 33,
  parameter int VisibleLines       = 480
) (
  input  logic       Pixelclock,
  input  logic       reset,
  input  logic       enable,
  input  logic       HSYNC,
  output logic       VSYNC,
  output logic [9:0] Y,
  output logic       line_visible,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int LT = VerticalFrontPorch + VSYNCPulse + VerticalBackPorch + VisibleLines;
  localparam logic [9:0] SYNC_START = 10'(VerticalFrontPorch);
  localparam logic [9:0] BP_START   = 10'(VerticalFrontPorch + VSYNCPulse);
  localparam logic [9:0] VIS_START  = 10'(VerticalFrontPorch + VSYNCPulse + VerticalBackPorch);
  localparam logic [9:0] LAST_LINE  = 10'(LT - 1);

  typedef enum logic [1:0] {V_FP, V_SYNC, V_BP, V_VIS} vstate_t;

  vstate_t    state, state_next;
  logic       hsync_q;
  logic       line_tick;
  logic       wrap;
  logic [9:0] line_cnt, line_cnt_next;

  // End of the horizontal sync pulse; an edge seen while disabled is dropped.
  assign line_tick = enable & HSYNC & ~hsync_q;
  assign wrap      = line_tick & (line_cnt == LAST_LINE);

  always_ff @(posedge Pixelclock or posedge reset) begin
    if (reset) hsync_q <= 1'b1;
    else       hsync_q <= HSYNC;
  end

  always_ff @(posedge Pixelclock or posedge reset) begin
    if (reset) begin
      state    <= V_FP;
      line_cnt <= '0;
    end else begin
      state    <= state_next;
      line_cnt <= line_cnt_next;
    end
  end

  always_comb begin
    line_cnt_next = line_cnt;
    state_next    = state;
    if (line_tick) begin
      line_cnt_next = wrap ? 10'd0 : line_cnt + 10'd1;
      case (state)
        V_FP:   if (line_cnt_next == SYNC_START) state_next = V_SYNC;
        V_SYNC: if (line_cnt_next == BP_START)   state_next = V_BP;
        V_BP:   if (line_cnt_next == VIS_START)  state_next = V_VIS;
        V_VIS:  if (line_cnt_next == 10'd0)      state_next = V_FP;
      endcase
    end
  end

  // Outputs follow the post-tick line, so they hold for the whole line.
  always_ff @(posedge Pixelclock or posedge reset) begin
    if (reset) begin
      VSYNC        <= 1'b1;
      Y            <= '0;
      line_visible <= 1'b0;
      frame_start  <= 1'b0;
      frame_count  <= '0;
    end else begin
      VSYNC        <= (state_next != V_SYNC);
      line_visible <= (state_next == V_VIS);
      Y            <= (state_next == V_VIS) ? line_cnt_next - VIS_START : 10'd0;
      frame_start  <= wrap;
      if (wrap) frame_count <= frame_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_vsync_provider.sv
// tb/tb_vsync_provider.sv - directed bench with a line-number model for default and 1/1/1/2 timings
module tb_vsync_provider;

  logic       Pixelclock;
  logic       reset;
  logic       enable;
  logic       HSYNC;
  logic       a_vsync, a_vis, a_fs;
  logic [9:0] a_y;
  logic [7:0] a_fc;
  logic       b_vsync, b_vis, b_fs;
  logic [9:0] b_y;
  logic [7:0] b_fc;

  int vectors = 0;
  int miscompares = 0;
  int fs_pulses_b = 0;

  vsync_provider dut_a (
    .Pixelclock(Pixelclock), .reset(reset), .enable(enable), .HSYNC(HSYNC),
    .VSYNC(a_vsync), .Y(a_y), .line_visible(a_vis), .frame_start(a_fs), .frame_count(a_fc)
  );

  vsync_provider #(
    .VerticalFrontPorch(1), .VSYNCPulse(1), .VerticalBackPorch(1), .VisibleLines(2)
  ) dut_b (
    .Pixelclock(Pixelclock), .reset(reset), .enable(enable), .HSYNC(HSYNC),
    .VSYNC(b_vsync), .Y(b_y), .line_visible(b_vis), .frame_start(b_fs), .frame_count(b_fc)
  );

  initial Pixelclock = 1'b0;
  always #5 Pixelclock = ~Pixelclock;

  // {VSYNC, Y, line_visible, frame_start, frame_count} from the line number alone
  function automatic logic [20:0] expect_vec(input int line, input int frames, input bit fs,
                                             input int fp, input int sy, input int bp);
    bit        vs, vis;
    logic [9:0] y;
    vs  = !(line >= fp && line < fp + sy);
    vis = (line >= fp + sy + bp);
    y   = vis ? 10'(line - (fp + sy + bp)) : 10'd0;
    return {vs, y, vis, fs, 8'(frames)};
  endfunction

  function automatic void advance(inout int line, inout int frames, output bit fs,
                                  input bit tick, input int lt);
    fs = 1'b0;
    if (tick) begin
      line = (line + 1) % lt;
      if (line == 0) begin
        fs = 1'b1;
        frames = (frames + 1) % 256;
      end
    end
  endfunction

  int  ma_line, ma_frames, mb_line, mb_frames;
  bit  ma_fs, mb_fs, m_prev, m_tick;
  logic [20:0] exp_a, exp_b, act_a, act_b;

  always begin
    @(posedge Pixelclock);
    if (reset) begin
      ma_line = 0; ma_frames = 0; ma_fs = 0;
      mb_line = 0; mb_frames = 0; mb_fs = 0;
      m_prev  = 1'b1;
    end else begin
      m_tick = enable && HSYNC && !m_prev;
      m_prev = HSYNC;
      advance(ma_line, ma_frames, ma_fs, m_tick, 525);
      advance(mb_line, mb_frames, mb_fs, m_tick, 5);
    end
    #1;
    exp_a = expect_vec(ma_line, ma_frames, ma_fs, 10, 2, 33);
    exp_b = expect_vec(mb_line, mb_frames, mb_fs, 1, 1, 1);
    act_a = {a_vsync, a_y, a_vis, a_fs, a_fc};
    act_b = {b_vsync, b_y, b_vis, b_fs, b_fc};
    vectors += 2;
    if (act_a !== exp_a) begin
      miscompares++;
      $display("FAIL model_a t=%0t got %h want %h (line %0d)", $time, act_a, exp_a, ma_line);
    end
    if (act_b !== exp_b) begin
      miscompares++;
      $display("FAIL model_b t=%0t got %h want %h (line %0d)", $time, act_b, exp_b, mb_line);
    end
    if (b_fs === 1'b1) fs_pulses_b++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, act, want);
    end
  endtask

  task automatic drive_line(input int len, input int lo_s, input int lo_e);
    for (int i = 0; i < len; i++) begin
      @(negedge Pixelclock);
      HSYNC = (i >= lo_s && i <= lo_e) ? 1'b0 : 1'b1;
    end
  endtask

  task automatic lines(input int n, input int len, input int lo_s, input int lo_e);
    for (int k = 0; k < n; k++) drive_line(len, lo_s, lo_e);
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    HSYNC  = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(negedge Pixelclock);
      HSYNC = ~HSYNC;
      check("reset_vsync", 32'(a_vsync), 1);
      check("reset_y", 32'(a_y), 0);
      check("reset_fc", 32'({a_vis, a_fs, a_fc}), 0);
    end
    @(negedge Pixelclock);
    reset = 1'b0;
    HSYNC = 1'b1;

    // full-length lines around the sync window
    for (int k = 1; k <= 12; k++) begin
      drive_line(800, 16, 111);
      check($sformatf("sync_line%0d", k), 32'(a_vsync), (k == 10 || k == 11) ? 0 : 1);
    end

    lines(32, 8, 2, 3);
    check("line44_vis", 32'(a_vis), 0);
    lines(1, 8, 2, 3);
    check("line45_vis", 32'(a_vis), 1);
    check("line45_y", 32'(a_y), 0);
    lines(55, 8, 2, 3);
    check("line100_y", 32'(a_y), 55);

    enable = 1'b0;
    lines(250, 8, 2, 3);
    check("freeze_y", 32'(a_y), 55);
    check("freeze_vsync", 32'(a_vsync), 1);
    enable = 1'b1;
    lines(1, 8, 2, 3);
    check("resume_y", 32'(a_y), 56);

    lines(423, 8, 2, 3);
    check("line524_y", 32'(a_y), 479);
    check("line524_fc", 32'(a_fc), 0);
    @(negedge Pixelclock); HSYNC = 1'b0;
    @(negedge Pixelclock); HSYNC = 1'b0;
    @(negedge Pixelclock); HSYNC = 1'b1;
    @(negedge Pixelclock);
    check("wrap_fs", 32'(a_fs), 1);
    check("wrap_y", 32'(a_y), 0);
    check("wrap_vis", 32'(a_vis), 0);
    check("wrap_fc", 32'(a_fc), 1);
    @(negedge Pixelclock);
    check("wrap_fs_drop", 32'(a_fs), 0);

    // mid-frame reset, then single-cycle HSYNC glitches as line ticks
    lines(300, 8, 2, 3);
    check("line300_y", 32'(a_y), 255);
    reset = 1'b1;
    #1;
    check("midreset_y", 32'(a_y), 0);
    check("midreset_fc", 32'(a_fc), 0);
    @(negedge Pixelclock);
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      drive_line(8, 3, 3);
      check($sformatf("restart_line%0d", k), 32'(a_vsync), (k == 10 || k == 11) ? 0 : 1);
    end

    // short-frame instance: frame counter wrap
    @(negedge Pixelclock); reset = 1'b1;
    @(negedge Pixelclock); reset = 1'b0;
    fs_pulses_b = 0;
    lines(1275, 4, 1, 1);
    check("small_fc255", 32'(b_fc), 255);
    lines(5, 4, 1, 1);
    check("small_fc_wrap", 32'(b_fc), 0);
    check("small_fs_pulses", 32'(fs_pulses_b), 256);
    check("big_fc_1280", 32'(a_fc), 2);

    // enable low across the wrap tick: wrap is lost, not deferred
    lines(4, 4, 1, 1);
    check("small_line4_y", 32'(b_y), 1);
    enable = 1'b0;
    drive_line(4, 1, 1);
    enable = 1'b1;
    check("nowrap_fc", 32'(b_fc), 0);
    drive_line(4, 1, 1);
    check("late_wrap_fc", 32'(b_fc), 1);
    drive_line(4, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
